// File: rtl/serial_adder.sv
// Bit-serial adder: one adder_unit processes operands LSB first, one bit per clock.
// Optional subtract mode (a - b) is enabled by defining SERIAL_ADDER_SUB_EN.

module adder_unit (
  input  logic a,
  input  logic b,
  input  logic c_in,
  output logic out,
  output logic c_out
);
  assign out   = a ^ b ^ c_in;
  assign c_out = (a & b) | (c_in & (a ^ b));
endmodule

module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic [1:0]       o_dbg_state
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_next_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_sum;
  logic             r_carry;
  logic [CW-1:0]    r_cnt;

  logic             w_accept;
  logic             w_run;
  logic             w_sum_bit;
  logic             w_carry;
  logic [WIDTH-1:0] w_b_load;
  logic             w_c_load;

  // Subtraction is a + ~b + 1; c_in is ignored in that mode.
`ifdef SERIAL_ADDER_SUB_EN
  assign w_b_load = sub ? ~b : b;
  assign w_c_load = sub ? 1'b1 : c_in;
`else
  assign w_b_load = b;
  assign w_c_load = c_in;
`endif

  assign w_accept = (r_state == S_IDLE) && start;
  assign w_run    = (r_state == S_RUN);

  adder_unit u_adder (
    .a     (r_a[0]),
    .b     (r_b[0]),
    .c_in  (r_carry),
    .out   (w_sum_bit),
    .c_out (w_carry)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    busy         = 1'b0;
    done         = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) w_next_state = S_RUN;
      end
      S_RUN: begin
        busy = 1'b1;
        if (r_cnt == LAST_BIT) w_next_state = S_DONE;
      end
      S_DONE: begin
        done         = 1'b1;
        w_next_state = S_IDLE;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // The carry register doubles as c_out: after the last bit it holds the carry out of the MSB.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
    end else if (w_accept) begin
      r_a     <= a;
      r_b     <= w_b_load;
      r_carry <= w_c_load;
      r_cnt   <= '0;
    end else if (w_run) begin
      r_a     <= {1'b0, r_a[WIDTH-1:1]};
      r_b     <= {1'b0, r_b[WIDTH-1:1]};
      r_sum   <= {w_sum_bit, r_sum[WIDTH-1:1]};
      r_carry <= w_carry;
      r_cnt   <= r_cnt + CW'(1);
    end
  end

  assign sum         = r_sum;
  assign c_out       = r_carry;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder (WIDTH=8): vector table plus hold-start and mid-run reset sequences.
// Define SERIAL_ADDER_SUB_EN to also exercise the subtract mode.

module tb_serial_adder;

  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         c_in;
  logic         sub;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         c_out;
  logic [1:0]   dbg_state;

  int n_cmp = 0;
  int n_err = 0;

  // Expected {c_out, sum} per accepted start.
  logic [W:0] exp_q[$];

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic [W-1:0] sum;
    logic         cout;
    string        name;
  } vec_t;

  vec_t vecs[10];

  serial_adder #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .a           (a),
    .b           (b),
    .c_in        (c_in),
`ifdef SERIAL_ADDER_SUB_EN
    .sub         (sub),
`endif
    .busy        (busy),
    .done        (done),
    .sum         (sum),
    .c_out       (c_out),
    .o_dbg_state (dbg_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Called just after a falling edge; returns at the falling edge after done has dropped.
  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tcin,
                        input logic [W:0] exp, input string name);
    int busy_cnt;
    int cyc;
    logic [W:0] e;
    exp_q.push_back(exp);
    a = ta; b = tb; c_in = tcin; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    // Scrambled operands after acceptance must not matter.
    a = W'($urandom_range(0, 255));
    b = W'($urandom_range(0, 255));
    c_in = 1'($urandom_range(0, 1));
    busy_cnt = 0;
    cyc = 0;
    while (!done && cyc < 40) begin
      if (busy) busy_cnt++;
      @(negedge clk);
      cyc++;
    end
    e = exp_q.pop_front();
    check({name, "_done_seen"}, 32'(done), 32'd1);
    check({name, "_busy_cycles"}, 32'(busy_cnt), 32'(W));
    check({name, "_sum"}, 32'(sum), 32'(e[W-1:0]));
    check({name, "_cout"}, 32'(c_out), 32'(e[W]));
    @(negedge clk);
    check({name, "_done_pulse"}, 32'(done), 32'd0);
    check({name, "_sum_hold"}, 32'({c_out, sum}), 32'(e));
  endtask

  initial begin
    int dcnt;
    logic [W:0] e;
    logic first_done;

    vecs[0] = '{8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, "v5a_3c"};
    vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, "vff_01"};
    vecs[2] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, "vff_ff_c"};
    vecs[3] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0, "vzero"};
    vecs[4] = '{8'h00, 8'h00, 1'b1, 8'h01, 1'b0, "vcin_only"};
    vecs[5] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, "vmsb"};
    vecs[6] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, "vripple"};
    vecs[7] = '{8'hAA, 8'h55, 1'b1, 8'h00, 1'b1, "valt_c"};
    vecs[8] = '{8'hC3, 8'h3D, 1'b0, 8'h00, 1'b1, "vwrap"};
    vecs[9] = '{8'h64, 8'hC8, 1'b1, 8'h2D, 1'b1, "v64_c8_c"};

    rst_n = 1'b0; start = 1'b0; a = '0; b = '0; c_in = 1'b0; sub = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_sum", 32'(sum), 32'd0);
    check("rst_cout", 32'(c_out), 32'd0);
    check("rst_state", 32'(dbg_state), 32'd0);

    // Start presented together with reset release: accepted on the first rising edge.
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].cin, {vecs[i].cout, vecs[i].sum}, vecs[i].name);
    end

    // start held high, operands scrambled while busy.
    a = 8'h11; b = 8'h22; c_in = 1'b0; start = 1'b1;
    exp_q.push_back({1'b0, 8'h33});
    dcnt = 0;
    first_done = 1'b1;
    for (int i = 1; i <= 26; i++) begin
      @(negedge clk);
      if (done) begin
        dcnt++;
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("hold_result", 32'({c_out, sum}), 32'(e));
        end else begin
          check("hold_extra_done", 32'(dcnt), 32'd2);
        end
        if (first_done) begin
          first_done = 1'b0;
          a = 8'h40; b = 8'h02; c_in = 1'b1;
          exp_q.push_back({1'b0, 8'h43});
        end else begin
          start = 1'b0;
        end
      end else if (busy) begin
        a = W'($urandom_range(0, 255));
        b = W'($urandom_range(0, 255));
      end
    end
    start = 1'b0;
    check("hold_done_count", 32'(dcnt), 32'd2);
    check("hold_queue_empty", 32'(exp_q.size()), 32'd0);
    @(negedge clk);

    // Reset in the middle of RUN.
    a = 8'h33; b = 8'h44; c_in = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("mid_busy_before", 32'(busy), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_sum", 32'(sum), 32'd0);
    check("mid_rst_cout", 32'(c_out), 32'd0);
    check("mid_rst_done", 32'(done), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    dcnt = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (done || busy) dcnt++;
    end
    check("mid_no_done", 32'(dcnt), 32'd0);
    run_op(8'h10, 8'h20, 1'b0, {1'b0, 8'h30}, "post_rst");

`ifdef SERIAL_ADDER_SUB_EN
    sub = 1'b1;
    run_op(8'h05, 8'h07, 1'b0, {1'b0, 8'hFE}, "sub_neg");
    run_op(8'h07, 8'h05, 1'b0, {1'b1, 8'h02}, "sub_pos");
    run_op(8'h07, 8'h05, 1'b1, {1'b1, 8'h02}, "sub_cin_ign");
    sub = 1'b0;
    run_op(8'h07, 8'h05, 1'b1, {1'b0, 8'h0D}, "sub_off");
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish, expected finish");
    $fatal(1, "timeout");
  end

endmodule
